// File: rtl/audio_dma_scheduler.sv
// DMA burst scheduler for the codec audio path: arbitrates playback refill vs
// record drain on one command port, supervises transfers, counts FIFO events.
module audio_dma_scheduler #(
  parameter int unsigned FIFO_DEPTH  = 1024,
  parameter int unsigned BURST_LEN   = 256,
  parameter int unsigned PB_LOW_WM   = 128,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic        axis_aclk,
  input  logic        axis_aresetn,
  input  logic        enable,
  input  logic        pb_enable,
  input  logic        rec_enable,
  input  logic [31:0] pb_level,
  input  logic [31:0] rec_level,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_dir,
  output logic [15:0] cmd_len,
  input  logic        xfer_done,
  input  logic        xfer_err,
  output logic        done_pulse,
  output logic        busy,
  output logic        irq,
  input  logic        irq_clear,
  output logic [1:0]  err_code,
  output logic [31:0] pb_underrun_cnt,
  output logic [31:0] rec_overflow_cnt,
  output logic [31:0] pb_burst_cnt,
  output logic [31:0] rec_burst_cnt
);

  localparam int unsigned LEVEL_W = 32;
  localparam int unsigned LEN_W   = 16;
  localparam int unsigned WD_W    = 16;

  localparam logic DIR_PB  = 1'b0;
  localparam logic DIR_REC = 1'b1;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_ERROR} state_t;

  state_t           state;
  logic             last_grant;
  logic [WD_W-1:0]  wd;
  logic             pb_uflow_q;
  logic             rec_oflow_q;

  logic [LEVEL_W:0] pb_space;
  logic             pb_req;
  logic             pb_urg;
  logic             rec_req;
  logic             pb_uflow;
  logic             rec_oflow;
  logic             grant_valid;
  logic             grant_dir;
  logic [WD_W:0]    wd_next;
  logic             wd_expired;

  // Free space goes negative (MSB set) when the level overshoots the depth.
  assign pb_space  = (LEVEL_W+1)'(FIFO_DEPTH) - {1'b0, pb_level};
  assign pb_req    = pb_enable && !pb_space[LEVEL_W] &&
                     (pb_space >= (LEVEL_W+1)'(BURST_LEN));
  assign pb_urg    = pb_req && (pb_level < LEVEL_W'(PB_LOW_WM));
  assign rec_req   = rec_enable && (rec_level >= LEVEL_W'(BURST_LEN));
  assign pb_uflow  = pb_enable && (pb_level == '0);
  assign rec_oflow = rec_enable && (rec_level >= LEVEL_W'(FIFO_DEPTH));

  assign wd_next    = {1'b0, wd} + (WD_W+1)'(1);
  assign wd_expired = (wd_next == (WD_W+1)'(TIMEOUT_CYC));

  // Urgent playback first, then round-robin against the previous grant.
  always_comb begin
    grant_valid = enable && (pb_req || rec_req);
    grant_dir   = DIR_PB;
    if (pb_urg)                grant_dir = DIR_PB;
    else if (pb_req && rec_req) grant_dir = ~last_grant;
    else if (rec_req)           grant_dir = DIR_REC;
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state            <= ST_IDLE;
      last_grant       <= DIR_REC;
      wd               <= '0;
      pb_uflow_q       <= 1'b0;
      rec_oflow_q      <= 1'b0;
      cmd_valid        <= 1'b0;
      cmd_dir          <= 1'b0;
      cmd_len          <= '0;
      done_pulse       <= 1'b0;
      busy             <= 1'b0;
      irq              <= 1'b0;
      err_code         <= 2'b00;
      pb_underrun_cnt  <= '0;
      rec_overflow_cnt <= '0;
      pb_burst_cnt     <= '0;
      rec_burst_cnt    <= '0;
    end else begin
      done_pulse  <= 1'b0;
      pb_uflow_q  <= pb_uflow;
      rec_oflow_q <= rec_oflow;
      if (pb_uflow && !pb_uflow_q)   pb_underrun_cnt  <= pb_underrun_cnt + 32'd1;
      if (rec_oflow && !rec_oflow_q) rec_overflow_cnt <= rec_overflow_cnt + 32'd1;

      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            state     <= ST_ISSUE;
            cmd_valid <= 1'b1;
            cmd_dir   <= grant_dir;
            cmd_len   <= LEN_W'(BURST_LEN);
            busy      <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (cmd_ready) begin
            state     <= ST_WAIT;
            cmd_valid <= 1'b0;
            wd        <= '0;
          end
        end
        ST_WAIT: begin
          // A completion arriving on the expiry cycle still counts as success.
          if (xfer_done && !xfer_err) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done_pulse <= 1'b1;
            last_grant <= cmd_dir;
            if (cmd_dir == DIR_PB) pb_burst_cnt  <= pb_burst_cnt + 32'd1;
            else                   rec_burst_cnt <= rec_burst_cnt + 32'd1;
          end else if (xfer_done) begin
            state    <= ST_ERROR;
            err_code <= 2'b01;
          end else if (wd_expired) begin
            state    <= ST_ERROR;
            err_code <= 2'b10;
          end else begin
            wd <= wd_next[WD_W-1:0];
          end
        end
        ST_ERROR: begin
          if (irq_clear) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            irq      <= 1'b0;
            err_code <= 2'b00;
          end else begin
            irq <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_dma_scheduler.sv
// Directed bench for audio_dma_scheduler; watchdog shortened to 20 cycles so
// timeout behaviour can be exercised quickly.
module tb_audio_dma_scheduler;

  logic        axis_aclk = 1'b0;
  logic        axis_aresetn;
  logic        enable, pb_enable, rec_enable;
  logic [31:0] pb_level, rec_level;
  logic        cmd_valid, cmd_ready, cmd_dir;
  logic [15:0] cmd_len;
  logic        xfer_done, xfer_err, done_pulse, busy, irq, irq_clear;
  logic [1:0]  err_code;
  logic [31:0] pb_underrun_cnt, rec_overflow_cnt, pb_burst_cnt, rec_burst_cnt;

  int errors = 0;
  int checks = 0;

  always #5 axis_aclk = ~axis_aclk;

  audio_dma_scheduler #(
    .FIFO_DEPTH(1024), .BURST_LEN(256), .PB_LOW_WM(128), .TIMEOUT_CYC(20)
  ) dut (
    .axis_aclk(axis_aclk), .axis_aresetn(axis_aresetn), .enable(enable),
    .pb_enable(pb_enable), .rec_enable(rec_enable), .pb_level(pb_level),
    .rec_level(rec_level), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_len(cmd_len), .xfer_done(xfer_done),
    .xfer_err(xfer_err), .done_pulse(done_pulse), .busy(busy), .irq(irq),
    .irq_clear(irq_clear), .err_code(err_code),
    .pb_underrun_cnt(pb_underrun_cnt), .rec_overflow_cnt(rec_overflow_cnt),
    .pb_burst_cnt(pb_burst_cnt), .rec_burst_cnt(rec_burst_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge axis_aclk);
  endtask

  task automatic wait_cmd(input string tag);
    int n = 0;
    while (cmd_valid !== 1'b1 && n < 20) begin
      @(negedge axis_aclk);
      n++;
    end
    chk({tag, "_valid"}, 32'(cmd_valid), 32'd1);
  endtask

  // One burst with immediate ready and done; returns on the done_pulse cycle.
  task automatic burst(input string tag, input logic err, input logic exp_dir);
    wait_cmd(tag);
    chk({tag, "_dir"}, 32'(cmd_dir), 32'(exp_dir));
    cmd_ready = 1'b1;
    @(negedge axis_aclk);
    cmd_ready = 1'b0;
    xfer_done = 1'b1;
    xfer_err  = err;
    @(negedge axis_aclk);
    xfer_done = 1'b0;
    xfer_err  = 1'b0;
    if (!err) chk({tag, "_done"}, 32'(done_pulse), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int seen;
    axis_aresetn = 1'b0;
    enable = 1'b0; pb_enable = 1'b0; rec_enable = 1'b0;
    pb_level = 32'd0; rec_level = 32'd0;
    cmd_ready = 1'b0; xfer_done = 1'b0; xfer_err = 1'b0; irq_clear = 1'b0;
    cycles(3);
    chk("rst_valid", 32'(cmd_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_err", 32'(err_code), 32'd0);
    chk("rst_len", 32'(cmd_len), 32'd0);
    chk("rst_pbcnt", pb_burst_cnt, 32'd0);
    chk("rst_reccnt", rec_burst_cnt, 32'd0);
    axis_aresetn = 1'b1;
    cycles(1);

    // Playback only, with a stalled handshake and enable dropped mid-ISSUE
    pb_level = 32'd100; pb_enable = 1'b1; enable = 1'b1;
    @(negedge axis_aclk);
    chk("pb_valid", 32'(cmd_valid), 32'd1);
    chk("pb_dir", 32'(cmd_dir), 32'd0);
    chk("pb_len", 32'(cmd_len), 32'd256);
    chk("pb_busy", 32'(busy), 32'd1);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge axis_aclk);
      chk("stall_valid", 32'(cmd_valid), 32'd1);
      chk("stall_len", 32'(cmd_len), 32'd256);
    end
    cmd_ready = 1'b1;
    @(negedge axis_aclk);
    cmd_ready = 1'b0;
    chk("hs_valid_drop", 32'(cmd_valid), 32'd0);
    chk("wait_busy", 32'(busy), 32'd1);
    pb_enable = 1'b0;
    xfer_done = 1'b1;
    @(negedge axis_aclk);
    xfer_done = 1'b0;
    chk("pb_done", 32'(done_pulse), 32'd1);
    chk("pb_cnt1", pb_burst_cnt, 32'd1);
    chk("pb_idle", 32'(busy), 32'd0);
    @(negedge axis_aclk);
    chk("pb_done_1cyc", 32'(done_pulse), 32'd0);

    axis_aresetn = 1'b0;
    @(negedge axis_aclk);
    axis_aresetn = 1'b1;
    chk("rst2_pbcnt", pb_burst_cnt, 32'd0);

    // Fairness: both continuous, not urgent
    pb_level = 32'd600; rec_level = 32'd300;
    pb_enable = 1'b1; rec_enable = 1'b1; enable = 1'b1;
    burst("fair0", 1'b0, 1'b0);
    burst("fair1", 1'b0, 1'b1);
    burst("fair2", 1'b0, 1'b0);
    burst("fair3", 1'b0, 1'b1);
    enable = 1'b0;
    chk("fair_pbcnt", pb_burst_cnt, 32'd2);
    chk("fair_reccnt", rec_burst_cnt, 32'd2);

    // Urgency overrides round-robin after a playback grant
    rec_enable = 1'b0; enable = 1'b1;
    burst("pre_urg", 1'b0, 1'b0);
    pb_level = 32'd50; rec_level = 32'd900; rec_enable = 1'b1;
    burst("urg", 1'b0, 1'b0);
    enable = 1'b0; rec_enable = 1'b0; pb_level = 32'd600;
    chk("urg_pbcnt", pb_burst_cnt, 32'd4);

    // DMA error
    enable = 1'b1;
    burst("err", 1'b1, 1'b0);
    chk("err_code01", 32'(err_code), 32'd1);
    @(negedge axis_aclk);
    chk("err_irq", 32'(irq), 32'd1);
    chk("err_busy", 32'(busy), 32'd1);
    seen = 0;
    repeat (100) begin
      @(negedge axis_aclk);
      if (cmd_valid) seen++;
    end
    chk("err_no_cmd", 32'(seen), 32'd0);
    chk("err_irq_sticky", 32'(irq), 32'd1);
    enable = 1'b0; irq_clear = 1'b1;
    @(negedge axis_aclk);
    irq_clear = 1'b0;
    chk("clr_irq", 32'(irq), 32'd0);
    chk("clr_err", 32'(err_code), 32'd0);
    chk("clr_busy", 32'(busy), 32'd0);

    // Watchdog timeout after 20 cycles in WAIT
    enable = 1'b1;
    wait_cmd("to");
    cmd_ready = 1'b1;
    @(negedge axis_aclk);
    cmd_ready = 1'b0; enable = 1'b0;
    cycles(19);
    chk("to_pre_err", 32'(err_code), 32'd0);
    chk("to_pre_busy", 32'(busy), 32'd1);
    @(negedge axis_aclk);
    chk("to_code10", 32'(err_code), 32'd2);
    @(negedge axis_aclk);
    chk("to_irq", 32'(irq), 32'd1);
    irq_clear = 1'b1;
    @(negedge axis_aclk);
    irq_clear = 1'b0;
    chk("to_clr_busy", 32'(busy), 32'd0);

    // Done on the expiry cycle wins
    enable = 1'b1;
    wait_cmd("co");
    cmd_ready = 1'b1;
    @(negedge axis_aclk);
    cmd_ready = 1'b0; enable = 1'b0;
    cycles(19);
    xfer_done = 1'b1;
    @(negedge axis_aclk);
    xfer_done = 1'b0;
    chk("co_done", 32'(done_pulse), 32'd1);
    chk("co_err", 32'(err_code), 32'd0);
    @(negedge axis_aclk);
    chk("co_irq", 32'(irq), 32'd0);
    chk("co_busy", 32'(busy), 32'd0);
    chk("co_pbcnt", pb_burst_cnt, 32'd5);

    // Playback/record request thresholds
    pb_level = 32'd769; enable = 1'b1;
    cycles(3);
    chk("pb769_none", 32'(cmd_valid), 32'd0);
    pb_level = 32'd2000;
    cycles(3);
    chk("pb2000_none", 32'(cmd_valid), 32'd0);
    pb_level = 32'd768;
    @(negedge axis_aclk);
    chk("pb768_req", 32'(cmd_valid), 32'd1);
    burst("pb768", 1'b0, 1'b0);
    pb_enable = 1'b0;
    rec_enable = 1'b1; rec_level = 32'd255;
    cycles(3);
    chk("rec255_none", 32'(cmd_valid), 32'd0);
    rec_level = 32'd256;
    @(negedge axis_aclk);
    chk("rec256_req", 32'(cmd_valid), 32'd1);
    burst("rec256", 1'b0, 1'b1);
    rec_enable = 1'b0; enable = 1'b0;

    // Underrun edges: 5 -> 0 -> 0 -> 3 -> 0
    pb_level = 32'd5; pb_enable = 1'b1;
    @(negedge axis_aclk);
    pb_level = 32'd0;
    @(negedge axis_aclk);
    @(negedge axis_aclk);
    pb_level = 32'd3;
    @(negedge axis_aclk);
    pb_level = 32'd0;
    @(negedge axis_aclk);
    chk("underrun_cnt", pb_underrun_cnt, 32'd2);
    pb_level = 32'd5; pb_enable = 1'b0;

    rec_enable = 1'b1; rec_level = 32'd1024;
    @(negedge axis_aclk);
    chk("overflow_cnt", rec_overflow_cnt, 32'd1);
    rec_level = 32'd100; rec_enable = 1'b0;

    // Stray done/clear while idle are ignored
    irq_clear = 1'b1; xfer_done = 1'b1;
    @(negedge axis_aclk);
    irq_clear = 1'b0; xfer_done = 1'b0;
    chk("stray_busy", 32'(busy), 32'd0);
    chk("stray_done", 32'(done_pulse), 32'd0);
    chk("stray_pbcnt", pb_burst_cnt, 32'd6);

    // Reset during ISSUE
    pb_level = 32'd600; pb_enable = 1'b1; enable = 1'b1;
    wait_cmd("rst_issue");
    #2 axis_aresetn = 1'b0;
    #1;
    chk("rsti_valid", 32'(cmd_valid), 32'd0);
    chk("rsti_busy", 32'(busy), 32'd0);
    chk("rsti_irq", 32'(irq), 32'd0);
    chk("rsti_pbcnt", pb_burst_cnt, 32'd0);
    chk("rsti_reccnt", rec_burst_cnt, 32'd0);
    chk("rsti_ucnt", pb_underrun_cnt, 32'd0);
    chk("rsti_ocnt", rec_overflow_cnt, 32'd0);
    @(negedge axis_aclk);
    axis_aresetn = 1'b1;
    @(negedge axis_aclk);
    chk("resume_valid", 32'(cmd_valid), 32'd1);
    burst("resume", 1'b0, 1'b0);
    enable = 1'b0; pb_enable = 1'b0;
    chk("resume_pbcnt", pb_burst_cnt, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
